alu_ex_stage: RTL and testbench
===============================

Name: alu_ex_stage

Overview:
- Execute stage that consumes the 3-bit alucontrol produced by the ALU decoder, together with both operands and writeback tags.
- Computes the ALU result, zero flag and signed-overflow flag.
- Holds the result in a 2-entry skid buffer: main register plus skid register, with valid/ready handshakes on both sides.
- Sits between the ID/EX boundary and the MEM stage; supports full throughput, back-pressure and pipeline flush.

Parameters:
- WIDTH, 32, operand and result width in bits.
- WA_W, 5, width of the destination register address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered and incoming operations this cycle.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  stage can accept an operation (registered).
- in_alucontrol  in  3  operation code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- in_srca  in  WIDTH  operand A.
- in_srcb  in  WIDTH  operand B.
- in_wa  in  WA_W  destination register address, passed through.
- in_regwrite  in  1  register write enable, passed through.
- out_valid  out  1  result available to MEM stage.
- out_ready  in  1  MEM stage accepts the result.
- out_result  out  WIDTH  ALU result.
- out_zero  out  1  out_result == 0.
- out_overflow  out  1  signed overflow (add/sub only).
- out_wa  out  WA_W  passed-through destination address.
- out_regwrite  out  1  passed-through write enable.

Behaviour:
- Accept occurs when in_valid & in_ready on a rising edge. Pop occurs when out_valid & out_ready.
- ALU evaluation is combinational on the input side. Only the computed result, flags and tags are stored; operands are not stored.
- Operation codes:
  - 010: a+b modulo 2^WIDTH.
  - 110: a-b modulo 2^WIDTH.
  - 000: a&b.
  - 001: a|b.
  - 111: result = 1 if $signed(a) < $signed(b), else 0.
  - 011, 100, 101: result 0, overflow 0.
- zero = (result == 0), for every operation code.
- overflow:
  - add: operands have the same sign and the result sign differs.
  - sub: operands have different signs and the result sign differs from a.
  - all other codes: 0.
- Buffer state is main_valid and skid_valid. out_valid = main_valid. Data outputs are driven from the main register.
- in_ready is a register, equal to ~skid_valid after each update.
- Per-cycle update, when not in reset or flush:
  - Pop and skid full: skid moves to main; skid_valid becomes 0.
  - Pop, skid empty, accept: new entry goes to main.
  - Pop, skid empty, no accept: main_valid becomes 0.
  - No pop, main empty, accept: new entry goes to main.
  - No pop, main full, accept: new entry goes to skid. Skid is necessarily empty because in_ready was 1.
  - Simultaneous pop and accept with skid full cannot occur, since in_ready is 0.
- Latency: accept at edge N gives out_valid = 1 after edge N, with the matching result.
- Sustained throughput is 1 operation per cycle while out_ready stays 1.
- Ordering is strictly FIFO: main always holds the older entry.
- While out_valid = 1 and out_ready = 0, all out_* data signals hold stable.
- Flush, when not in reset:
  - On the next edge, main_valid = 0, skid_valid = 0 and in_ready = 1.
  - An operation presented in the flush cycle is not accepted.
  - A pop handshake in the flush cycle still completes downstream.
- Reset (rst high at an edge), including mid-stream:
  - main_valid = 0, skid_valid = 0, in_ready = 1.
  - out_result = 0, out_zero = 0, out_overflow = 0, out_wa = 0, out_regwrite = 0.
  - Inputs are ignored in the reset cycle.
  - rst takes priority over flush.
- Data registers update only when their entry is loaded. Stale data under valid = 0 is don't-care, except immediately after reset, where it is 0.

Test Plan:
- Reset then single op: alucontrol 010, a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0; out_wa and out_regwrite match the inputs.
- Ops sweep with out_ready=1:
  - sub 5-5 -> result 0, zero=1.
  - and 0xF0F0&0x0FF0 -> 0x00F0.
  - or 0xF000|0x000F -> 0xF00F.
  - slt a=0xFFFFFFFF (-1), b=1 -> 1.
  - slt a=1, b=0xFFFFFFFF -> 0.
  - code 100 -> result 0, zero=1, overflow=0.
- Back-pressure: stream of 4 ops (add i+i for i=1..4) with out_ready=0 after the first accept -> in_ready drops to 0 after two accepts. Raise out_ready -> outputs 2, 4, 6, 8 in order, with no drop or duplicate.
- Full-rate streaming: 16 back-to-back ops with out_ready=1 -> in_ready stays 1 and one result emerges per cycle, 1-cycle latency each.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed ops and the op presented in the flush cycle never appear.
- Reset mid-stream with skid full -> next cycle out_valid=0, in_ready=1, out_result=0; the following op is accepted normally.

Source files
------------

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute stage behind the ALU decoder.
// Evaluates the ALU on the incoming operands. It then registers only the
// result, the flags and the writeback tags in a 2-entry skid buffer.
// The buffer has a main register and a skid register. Main always holds
// the older entry and drives the outputs. in_ready is registered.
module alu_ex_stage #(
  parameter int WIDTH = 32,
  parameter int WA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_alucontrol,
  input  logic [WIDTH-1:0] in_srca,
  input  logic [WIDTH-1:0] in_srcb,
  input  logic [WA_W-1:0]  in_wa,
  input  logic             in_regwrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [WA_W-1:0]  out_wa,
  output logic             out_regwrite
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // One buffered entry: everything MEM needs, but no operands.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic [WA_W-1:0]  wa;
    logic             rw;
  } ent_t;

  // ---------------------------------------------------------------------
  // ALU (input side, combinational)
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sum, diff;
  logic             a_msb, b_msb, slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  ent_t             new_ent;

  assign sum     = in_srca + in_srcb;
  assign diff    = in_srca - in_srcb;
  assign a_msb   = in_srca[WIDTH-1];
  assign b_msb   = in_srcb[WIDTH-1];
  assign slt_bit = $signed(in_srca) < $signed(in_srcb);

  // Select the result by opcode. Undefined codes yield 0 with no overflow.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (in_alucontrol)
      OP_ADD: begin
        alu_res = sum;
        // Equal operand signs, yet the result sign flipped.
        alu_ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        alu_res = diff;
        // Operand signs differ, and the result sign differs from a.
        alu_ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
      end
      OP_AND:  alu_res = in_srca & in_srcb;
      OP_OR:   alu_res = in_srca | in_srcb;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_res = '0;
    endcase
  end

  // Pack the computed result, flags and tags into one buffer entry.
  always_comb begin
    new_ent        = '0;
    new_ent.result = alu_res;
    new_ent.zero   = (alu_res == '0);
    new_ent.ovf    = alu_ovf;
    new_ent.wa     = in_wa;
    new_ent.rw     = in_regwrite;
  end

  // ---------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------
  ent_t main_q, main_d, skid_q, skid_d;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic in_ready_q, in_ready_d;
  logic accept, pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = main_vld_q & out_ready;

  // Next-state logic for the buffer. A flush drops both entries. During a
  // flush the ready path is ignored, so the op presented never enters.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (pop) begin
      if (skid_vld_q) begin
        // in_ready was low, so no accept can coincide here.
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = new_ent;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q) begin
        main_d     = new_ent;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = new_ent;
        skid_vld_d = 1'b1;
      end
    end
    in_ready_d = ~skid_vld_d;
  end

  // Buffer state. Reset wins over flush and clears the data registers too.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_vld_q;
  assign out_result   = main_q.result;
  assign out_zero     = main_q.zero;
  assign out_overflow = main_q.ovf;
  assign out_wa       = main_q.wa;
  assign out_regwrite = main_q.rw;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage. The stimulus pushes hand-computed
// expectations on each accept. The monitor pops and compares on each pop.
module tb_alu_ex_stage;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_regwrite;
  logic [2:0]    in_alucontrol;
  logic [W-1:0]  in_srca, in_srcb, out_result;
  logic [AW-1:0] in_wa, out_wa;
  logic          out_valid, out_ready, out_zero, out_overflow, out_regwrite;

  always #5 clk = ~clk;

  alu_ex_stage #(.WIDTH(W), .WA_W(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alucontrol(in_alucontrol),
    .in_srca(in_srca), .in_srcb(in_srcb), .in_wa(in_wa), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_wa(out_wa),
    .out_regwrite(out_regwrite)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic          z;
    logic          v;
    logic [AW-1:0] wa;
    logic          rw;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: each pop handshake consumes the oldest expectation.
  exp_t e_mon;
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got result %0h, expected no output", out_result);
      end else begin
        e_mon = q.pop_front();
        chk("result",   out_result,   e_mon.res);
        chk("zero",     out_zero,     e_mon.z);
        chk("overflow", out_overflow, e_mon.v);
        chk("wa",       out_wa,       e_mon.wa);
        chk("regwrite", out_regwrite, e_mon.rw);
        if (chk_lat) chk("latency", cyc - e_mon.acc, 1);
      end
    end
  end

  // Present one op and hold it until accepted; record the expectation.
  task automatic send(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [AW-1:0] wa, input logic rw,
                      input logic [W-1:0] er, input logic ez, input logic ev);
    exp_t e;
    bit   ok = 1'b0;
    in_valid = 1'b1; in_alucontrol = c; in_srca = a; in_srcb = b;
    in_wa = wa; in_regwrite = rw;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && !rst && !flush) begin
        ok = 1'b1;
        e.res = er; e.z = ez; e.v = ev; e.wa = wa; e.rw = rw; e.acc = cyc;
      end
      @(posedge clk); #1;
    end
    if (ok) q.push_back(e);
    else begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
    @(posedge clk); #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_alucontrol = '0;
    in_srca = '0; in_srcb = '0; in_wa = '0; in_regwrite = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_result",    out_result, 0);
    chk("rst_zero",      out_zero, 0);
    chk("rst_wa",        out_wa, 0);
    @(posedge clk); #1;

    // First op and opcode sweep at full rate
    chk_lat = 1'b1; out_ready = 1'b1;
    send(3'b010, 32'h7FFF_FFFF, 32'h1, 5'd7, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    send(3'b110, 32'd5, 32'd5, 5'd3, 1'b0, 32'h0, 1'b1, 1'b0);
    send(3'b000, 32'hF0F0, 32'h0FF0, 5'd4, 1'b1, 32'h00F0, 1'b0, 1'b0);
    send(3'b001, 32'hF000, 32'h000F, 5'd5, 1'b1, 32'hF00F, 1'b0, 1'b0);
    send(3'b111, 32'hFFFF_FFFF, 32'h1, 5'd6, 1'b1, 32'h1, 1'b0, 1'b0);
    send(3'b111, 32'h1, 32'hFFFF_FFFF, 5'd8, 1'b0, 32'h0, 1'b1, 1'b0);
    send(3'b100, 32'h123, 32'h456, 5'd9, 1'b1, 32'h0, 1'b1, 1'b0);
    send(3'b110, 32'h8000_0000, 32'h1, 5'd10, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    send(3'b010, 32'hFFFF_FFFF, 32'h1, 5'd11, 1'b1, 32'h0, 1'b1, 1'b0);
    drain();

    // Back-pressure: two accepts fill the buffer, the third must stall
    chk_lat = 1'b0; out_ready = 1'b0;
    send(3'b010, 32'd1, 32'd1, 5'd1, 1'b1, 32'd2, 1'b0, 1'b0);
    send(3'b010, 32'd2, 32'd2, 5'd2, 1'b1, 32'd4, 1'b0, 1'b0);
    in_valid = 1'b1; in_alucontrol = 3'b010; in_srca = 32'd3; in_srcb = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stall_result", out_result, 2);
      chk("bp_stall_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'b010, 32'd3, 32'd3, 5'd3, 1'b1, 32'd6, 1'b0, 1'b0);
    send(3'b010, 32'd4, 32'd4, 5'd4, 1'b1, 32'd8, 1'b0, 1'b0);
    drain();

    // Full-rate stream: one accept per cycle
    chk_lat = 1'b1;
    begin
      int c0;
      c0 = cyc;
      for (int i = 1; i <= 16; i++) begin
        logic [W-1:0] a;
        a = i;
        send(3'b010, a, a << 4, a[AW-1:0], a[0], a * 17, 1'b0, 1'b0);
      end
      chk("stream_cycles", cyc - c0, 16);
    end
    drain();

    // Flush with both entries full and an op presented
    chk_lat = 1'b0; out_ready = 1'b0;
    send(3'b010, 32'd10, 32'd10, 5'd12, 1'b1, 32'd20, 1'b0, 1'b0);
    send(3'b010, 32'd1, 32'd1, 5'd13, 1'b1, 32'd2, 1'b0, 1'b0);
    in_valid = 1'b1; in_srca = 32'd5; in_srcb = 32'd5; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_stays_empty", out_valid, 0);
    end
    @(posedge clk); #1;

    // Flush with only main full, so in_ready=1 during the flush
    out_ready = 1'b0;
    send(3'b001, 32'h1, 32'h2, 5'd14, 1'b1, 32'h3, 1'b0, 1'b0);
    in_valid = 1'b1; in_alucontrol = 3'b010; in_srca = 32'd7; in_srcb = 32'd7; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush2_out_valid", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1; chk_lat = 1'b1;
    send(3'b000, 32'hFF00, 32'h0FF0, 5'd15, 1'b0, 32'h0F00, 1'b0, 1'b0);
    drain();

    // Reset mid-stream with skid full
    chk_lat = 1'b0; out_ready = 1'b0;
    send(3'b010, 32'd20, 32'd1, 5'h1F, 1'b1, 32'd21, 1'b0, 1'b0);
    send(3'b010, 32'd30, 32'd1, 5'h1E, 1'b1, 32'd31, 1'b0, 1'b0);
    in_valid = 1'b1; in_srca = 32'd9; in_srcb = 32'd9; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready",  in_ready, 1);
    chk("mrst_result",    out_result, 0);
    chk("mrst_zero",      out_zero, 0);
    chk("mrst_overflow",  out_overflow, 0);
    chk("mrst_wa",        out_wa, 0);
    chk("mrst_regwrite",  out_regwrite, 0);
    @(posedge clk); #1;
    out_ready = 1'b1; chk_lat = 1'b1;
    send(3'b110, 32'h10, 32'h20, 5'd9, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
